// File: rtl/motor_ramp_ctrl.sv
// N-channel H-bridge motor controller: shared PWM period counter, per-channel
// slew-limited duty ramp and dead-time protected direction reversal.
module motor_ramp_ctrl #(
    parameter int              N_CH      = 2,
    parameter int              DUTY_W    = 10,
    parameter int              CLK_HZ    = 100_000_000,
    parameter int              PWM_HZ    = 25_000,
    parameter int              DUTY_MAX  = 700,
    parameter int              RAMP_STEP = 16,
    parameter int              RAMP_DIV  = 4,
    parameter int              DEAD_PER  = 2,
    parameter logic [N_CH-1:0] DIR_INV   = '0,
    localparam int             CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [CH_W-1:0]   cmd_ch,
    input  logic [1:0]        cmd_mode,
    input  logic [DUTY_W-1:0] cmd_duty,
    output logic              cmd_err,
    output logic [N_CH-1:0]   pwm,
    output logic [N_CH-1:0]   in_a,
    output logic [N_CH-1:0]   in_b,
    output logic [N_CH-1:0]   busy,
    output logic              period_end
);

    localparam int PERIOD = CLK_HZ / PWM_HZ;
    localparam int CNT_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int PROD_W = DUTY_W + CNT_W;
    localparam int DIV_W  = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int DEAD_W = (DEAD_PER > 1) ? $clog2(DEAD_PER) : 1;
    localparam logic [DUTY_W-1:0] STEP = DUTY_W'(RAMP_STEP);

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_RAMP_DN, S_DEAD, S_BRAKE} state_e;
    typedef enum logic [1:0] {M_COAST, M_FWD, M_REV, M_BRAKE} mode_e;

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic              ready_q, err_q, err_d;
    logic [N_CH-1:0]   pwm_q, pwm_d, a_q, a_d, b_q, b_d;
    state_e            state_q [N_CH];
    state_e            state_d [N_CH];
    logic              dir_q [N_CH];
    logic              dir_d [N_CH];
    mode_e             tgt_mode_q [N_CH];
    mode_e             tgt_mode_d [N_CH];
    logic [DUTY_W-1:0] tgt_duty_q [N_CH];
    logic [DUTY_W-1:0] tgt_duty_d [N_CH];
    logic [DUTY_W-1:0] cur_q [N_CH];
    logic [DUTY_W-1:0] cur_d [N_CH];
    logic [DEAD_W-1:0] dead_q [N_CH];
    logic [DEAD_W-1:0] dead_d [N_CH];

    logic              tick, accept, hit, drive, rv, cmd_rev;
    mode_e             cmd_mode_e;
    logic [DUTY_W-1:0] cmd_duty_c;

    function automatic logic [CNT_W-1:0] thr_f(input logic [DUTY_W-1:0] d);
        logic [PROD_W-1:0] p;
        p = PROD_W'(d) * PROD_W'(PERIOD);
        return p[PROD_W-1:DUTY_W];
    endfunction

    function automatic logic [DUTY_W-1:0] step_f(input logic [DUTY_W-1:0] cur,
                                                 input logic [DUTY_W-1:0] tgt);
        if (cur < tgt) return (tgt - cur > STEP) ? cur + STEP : tgt;
        return (cur - tgt > STEP) ? cur - STEP : tgt;
    endfunction

    assign period_end = (cnt_q == CNT_W'(PERIOD - 1));
    assign accept     = cmd_valid && cmd_ready;
    assign cmd_mode_e = mode_e'(cmd_mode);
    assign cmd_duty_c = (32'(cmd_duty) > DUTY_MAX) ? DUTY_W'(DUTY_MAX) : cmd_duty;

    always_comb begin
        cnt_d   = period_end ? '0 : cnt_q + CNT_W'(1);
        tick    = period_end && (div_q == DIV_W'(RAMP_DIV - 1));
        div_d   = div_q;
        if (period_end) div_d = tick ? '0 : div_q + DIV_W'(1);
        err_d   = accept && (32'(cmd_ch) >= N_CH);
        pwm_d   = '0;
        a_d     = '0;
        b_d     = '0;
        hit     = 1'b0;
        drive   = 1'b0;
        rv      = 1'b0;
        cmd_rev = (cmd_mode_e == M_REV);
        for (int unsigned i = 0; i < N_CH; i++) begin
            state_d[i]    = state_q[i];
            dir_d[i]      = dir_q[i];
            tgt_mode_d[i] = tgt_mode_q[i];
            tgt_duty_d[i] = tgt_duty_q[i];
            cur_d[i]      = cur_q[i];
            dead_d[i]     = dead_q[i];

            // Period-boundary work sees the targets as they were before any
            // command landing on the same edge.
            case (state_q[i])
                S_RUN: if (tick) cur_d[i] = step_f(cur_q[i], tgt_duty_q[i]);
                S_RAMP_DN: if (period_end) begin
                    if (cur_q[i] == '0) begin
                        state_d[i] = S_DEAD;
                        dead_d[i]  = '0;
                    end else if (tick) begin
                        cur_d[i] = step_f(cur_q[i], '0);
                    end
                end
                S_DEAD: if (period_end) begin
                    if (dead_q[i] != DEAD_W'(DEAD_PER - 1)) begin
                        dead_d[i] = dead_q[i] + DEAD_W'(1);
                    end else if (tgt_mode_q[i] == M_FWD || tgt_mode_q[i] == M_REV) begin
                        state_d[i] = S_RUN;
                        dir_d[i]   = (tgt_mode_q[i] == M_REV);
                        if (tick) cur_d[i] = step_f('0, tgt_duty_q[i]);
                    end else begin
                        state_d[i] = S_IDLE;
                    end
                end
                default: ;
            endcase

            hit = accept && en && (32'(cmd_ch) == i);
            if (hit) begin
                tgt_mode_d[i] = cmd_mode_e;
                tgt_duty_d[i] = cmd_duty_c;
                case (cmd_mode_e)
                    M_COAST: begin state_d[i] = S_IDLE;  cur_d[i] = '0; end
                    M_BRAKE: begin state_d[i] = S_BRAKE; cur_d[i] = '0; end
                    default: case (state_q[i])
                        S_IDLE, S_BRAKE: begin
                            state_d[i] = S_RUN;
                            dir_d[i]   = cmd_rev;
                            cur_d[i]   = '0;
                        end
                        S_RUN:     if (cmd_rev != dir_q[i]) state_d[i] = S_RAMP_DN;
                        S_RAMP_DN: if (cmd_rev == dir_q[i]) state_d[i] = S_RUN;
                        default: ;
                    endcase
                endcase
            end

            if (!en) begin
                state_d[i]    = S_IDLE;
                cur_d[i]      = '0;
                tgt_mode_d[i] = M_COAST;
                tgt_duty_d[i] = '0;
                dead_d[i]     = '0;
            end

            drive    = (state_d[i] == S_RUN) || (state_d[i] == S_RAMP_DN);
            rv       = dir_d[i] ^ DIR_INV[i];
            a_d[i]   = (drive && !rv) || (state_d[i] == S_BRAKE);
            b_d[i]   = (drive && rv)  || (state_d[i] == S_BRAKE);
            pwm_d[i] = drive && (cnt_d < thr_f(cur_d[i]));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            div_q   <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            pwm_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            for (int unsigned i = 0; i < N_CH; i++) begin
                state_q[i]    <= S_IDLE;
                dir_q[i]      <= 1'b0;
                tgt_mode_q[i] <= M_COAST;
                tgt_duty_q[i] <= '0;
                cur_q[i]      <= '0;
                dead_q[i]     <= '0;
            end
        end else begin
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            ready_q    <= 1'b1;
            err_q      <= err_d;
            pwm_q      <= pwm_d;
            a_q        <= a_d;
            b_q        <= b_d;
            state_q    <= state_d;
            dir_q      <= dir_d;
            tgt_mode_q <= tgt_mode_d;
            tgt_duty_q <= tgt_duty_d;
            cur_q      <= cur_d;
            dead_q     <= dead_d;
        end
    end

    always_comb begin
        busy = '0;
        for (int unsigned i = 0; i < N_CH; i++)
            busy[i] = (state_q[i] == S_RAMP_DN) || (state_q[i] == S_DEAD);
    end

    assign cmd_ready = ready_q;
    assign cmd_err   = err_q;
    assign pwm       = pwm_q;
    assign in_a      = a_q;
    assign in_b      = b_q;

endmodule

// File: tb/tb_motor_ramp_ctrl.sv
// Bench for motor_ramp_ctrl: per-period PWM/IN/busy records scored against
// hand-computed expectations queued by the stimulus process.
module tb_motor_ramp_ctrl;

    localparam logic [1:0] COAST = 2'd0, FWD = 2'd1, REV = 2'd2, BRK = 2'd3;

    logic       clk = 1'b0;
    logic       rst, en, cmd_valid, cmd_ready, cmd_err, period_end;
    logic [1:0] cmd_ch, cmd_mode;
    logic [3:0] cmd_duty;
    logic [2:0] pwm, in_a, in_b, busy;

    always #5 clk = ~clk;

    motor_ramp_ctrl #(
        .N_CH(3), .DUTY_W(4), .CLK_HZ(1000), .PWM_HZ(100), .DUTY_MAX(10),
        .RAMP_STEP(4), .RAMP_DIV(1), .DEAD_PER(2), .DIR_INV(3'b010)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_ch(cmd_ch), .cmd_mode(cmd_mode), .cmd_duty(cmd_duty), .cmd_err(cmd_err),
        .pwm(pwm), .in_a(in_a), .in_b(in_b), .busy(busy), .period_end(period_end)
    );

    typedef struct {
        int pidx;
        int ch;
        int hi;
        int ac;
        int bc;
        int bz;
    } exp_t;

    exp_t expq[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   pidx   = 0;
    int   hi[3], ac[3], bc[3], bz[3];

    // Monitor: accumulate one PWM period per channel, score queued records.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                for (int c = 0; c < 3; c++) begin hi[c] = 0; ac[c] = 0; bc[c] = 0; bz[c] = 0; end
            end else begin
                for (int c = 0; c < 3; c++) begin
                    hi[c] = hi[c] + (pwm[c] ? 1 : 0);
                    ac[c] = ac[c] + (in_a[c] ? 1 : 0);
                    bc[c] = bc[c] + (in_b[c] ? 1 : 0);
                    bz[c] = bz[c] + (busy[c] ? 1 : 0);
                end
                if (period_end) begin
                    while (expq.size() > 0 && expq[0].pidx <= pidx) begin
                        mon_e = expq.pop_front();
                        checks++;
                        if (mon_e.pidx < pidx) begin
                            errors++;
                            $display("FAIL period_missed p%0d ch%0d: not observed, now at p%0d",
                                     mon_e.pidx, mon_e.ch, pidx);
                        end else if (hi[mon_e.ch] != mon_e.hi || ac[mon_e.ch] != mon_e.ac ||
                                     bc[mon_e.ch] != mon_e.bc || bz[mon_e.ch] != mon_e.bz) begin
                            errors++;
                            $display("FAIL period p%0d ch%0d actual hi=%0d a=%0d b=%0d busy=%0d required hi=%0d a=%0d b=%0d busy=%0d",
                                     pidx, mon_e.ch, hi[mon_e.ch], ac[mon_e.ch], bc[mon_e.ch], bz[mon_e.ch],
                                     mon_e.hi, mon_e.ac, mon_e.bc, mon_e.bz);
                        end
                    end
                    pidx++;
                    for (int c = 0; c < 3; c++) begin hi[c] = 0; ac[c] = 0; bc[c] = 0; bz[c] = 0; end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic push_exp(input int p, input int ch, input int h, input int a, input int b, input int bsy);
        exp_t e;
        e.pidx = p; e.ch = ch; e.hi = h; e.ac = a; e.bc = b; e.bz = bsy;
        expq.push_back(e);
    endtask

    // Returns just after the negedge of the last cycle of a period.
    task automatic sync_pe();
        int n = 0;
        do begin @(negedge clk); n++; end while (!period_end && n < 100);
        if (!period_end) check("period_end_timeout", 0, 1);
        #1;
    endtask

    task automatic wait_periods(input int n);
        repeat (n) sync_pe();
    endtask

    task automatic send(input logic [1:0] ch, input logic [1:0] mode, input logic [3:0] duty);
        cmd_valid = 1'b1; cmd_ch = ch; cmd_mode = mode; cmd_duty = duty;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    // Command accepted on the wrap edge; p is the period that edge starts.
    task automatic bsend(input logic [1:0] ch, input logic [1:0] mode, input logic [3:0] duty, output int p);
        sync_pe();
        p = pidx;
        send(ch, mode, duty);
    endtask

    int p, n;

    initial begin
        rst = 1'b1; en = 1'b1; cmd_valid = 1'b0; cmd_ch = '0; cmd_mode = COAST; cmd_duty = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {pwm, in_a, in_b, busy, cmd_err, period_end, cmd_ready}, 0);
        #1 rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", cmd_ready, 1);

        // Ramp up from idle; duty 15 clamps to 10; thr = 0,2,5,6
        bsend(0, FWD, 4'd15, p);
        push_exp(p, 0, 0, 10, 0, 0);   push_exp(p+1, 0, 2, 10, 0, 0);
        push_exp(p+2, 0, 5, 10, 0, 0); push_exp(p+3, 0, 6, 10, 0, 0);
        push_exp(p+4, 0, 6, 10, 0, 0);
        wait_periods(4);

        // Reversal: ramp 10->6->2->0, one zero period, dead 2 periods, then rev 4,8
        bsend(0, REV, 4'd8, p);
        push_exp(p, 0, 6, 10, 0, 10);   push_exp(p+1, 0, 3, 10, 0, 10);
        push_exp(p+2, 0, 1, 10, 0, 10); push_exp(p+3, 0, 0, 10, 0, 10);
        push_exp(p+4, 0, 0, 0, 0, 10);  push_exp(p+5, 0, 0, 0, 0, 10);
        push_exp(p+6, 0, 2, 0, 10, 0);  push_exp(p+7, 0, 5, 0, 10, 0);
        push_exp(p+8, 0, 5, 0, 10, 0);
        wait_periods(8);

        // ch1 is mirror-mounted: forward drives in_b
        bsend(1, FWD, 4'd12, p);
        push_exp(p, 1, 0, 0, 10, 0);   push_exp(p+1, 1, 2, 0, 10, 0);
        push_exp(p+2, 1, 5, 0, 10, 0); push_exp(p+3, 1, 6, 0, 10, 0);
        wait_periods(4);
        repeat (3) @(negedge clk);
        #1;
        send(1, BRK, 4'd0);
        check("brake_next_cycle", {in_a[1], in_b[1], pwm[1]}, 3'b110);
        sync_pe();
        push_exp(pidx, 1, 0, 10, 10, 0);
        bsend(1, FWD, 4'd8, p);
        push_exp(p, 1, 0, 0, 10, 0);   push_exp(p+1, 1, 2, 0, 10, 0);
        push_exp(p+2, 1, 5, 0, 10, 0); push_exp(p+3, 1, 5, 0, 10, 0);
        wait_periods(3);

        // Out-of-range channel: error pulse, nothing else moves
        bsend(2'd3, FWD, 4'd5, p);
        check("cmd_err_pulse", cmd_err, 1);
        @(posedge clk); #1;
        check("cmd_err_one_cycle", cmd_err, 0);
        push_exp(p, 0, 5, 0, 10, 0);
        push_exp(p, 1, 5, 0, 10, 0);
        push_exp(p, 2, 0, 0, 0, 0);

        // ch2 normal mount: forward drives in_a; disable mid-ramp
        bsend(2, FWD, 4'd15, p);
        push_exp(p, 2, 0, 10, 0, 0);
        push_exp(p+1, 2, 2, 10, 0, 0);
        wait_periods(2);
        repeat (2) @(negedge clk);
        #1 en = 1'b0;
        @(posedge clk); #1;
        check("en_off_outputs", {pwm, in_a, in_b, busy}, 0);
        send(2, FWD, 4'd10);
        check("en_off_cmd_ignored", {pwm, in_a, in_b}, 0);
        en = 1'b1;
        sync_pe();
        push_exp(pidx, 0, 0, 0, 0, 0);
        push_exp(pidx, 1, 0, 0, 0, 0);
        push_exp(pidx, 2, 0, 0, 0, 0);

        // Drive ch0 into DEAD, then reset there
        bsend(0, FWD, 4'd4, p);
        push_exp(p, 0, 0, 10, 0, 0);
        push_exp(p+1, 0, 2, 10, 0, 0);
        wait_periods(1);
        bsend(0, REV, 4'd4, p);
        push_exp(p, 0, 2, 10, 0, 10);
        push_exp(p+1, 0, 0, 10, 0, 10);
        wait_periods(2);
        repeat (3) @(negedge clk);
        check("dead_state", {busy[0], in_a[0], in_b[0]}, 3'b100);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        check("reset_in_dead", {pwm, in_a, in_b, busy, cmd_err, period_end, cmd_ready}, 0);
        @(negedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("ready_after_release", cmd_ready, 1);
        n = 1;
        while (!period_end && n < 50) begin @(negedge clk); n++; end
        check("cnt_restart_from_0", n, 9);
        bsend(0, FWD, 4'd10, p);
        push_exp(p, 0, 0, 10, 0, 0);   push_exp(p+1, 0, 2, 10, 0, 0);
        push_exp(p+2, 0, 5, 10, 0, 0); push_exp(p+3, 0, 6, 10, 0, 0);

        n = 0;
        while (expq.size() > 0 && n < 200) begin @(negedge clk); n++; end
        #1;
        check("scoreboard_drained", expq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
